// File: rtl/vga_fb_pixel_stream.sv
// vga_fb_pixel_stream: framebuffer scan-out engine. Walks the VGA raster, prefetches
// visible pixels from SRAM over AXI-Lite read channels and presents one sync/colour
// beat per raster position on a valid/ready stream.
module vga_fb_pixel_stream #(
    parameter int H_VISIBLE      = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_VISIBLE      = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int COLOR_BITS     = 4,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int FB_BASE        = 0,
    parameter int PREFETCH       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      hsync,
    output logic                      vsync,
    output logic [COLOR_BITS-1:0]     red,
    output logic [COLOR_BITS-1:0]     green,
    output logic [COLOR_BITS-1:0]     blue,
    output logic                      visible,
    output logic                      rd_err
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int XW       = $clog2(H_TOTAL);
    localparam int YW       = $clog2(V_TOTAL);
    localparam int VIS_PIX  = H_VISIBLE * V_VISIBLE;
    localparam int FW       = (VIS_PIX > 1) ? $clog2(VIS_PIX) : 1;
    localparam int PW       = $clog2(PREFETCH);
    localparam int CW       = $clog2(PREFETCH + 1);
    localparam int PIXW     = 3 * COLOR_BITS;

    localparam logic [XW-1:0]             X_LAST    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]             Y_LAST    = YW'(V_TOTAL - 1);
    localparam logic [FW-1:0]             F_LAST    = FW'(VIS_PIX - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = AXI_ADDR_WIDTH'(FB_BASE);

    // raster position of the next beat to be loaded into the output register
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // fetch side
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                      arvalid_q, arvalid_d;
    logic [FW-1:0]             fetch_cnt_q, fetch_cnt_d;
    logic [CW-1:0]             credits_q, credits_d;
    logic                      rready_q, rready_d;
    logic                      rd_err_q, rd_err_d;

    // read-data queue; top bit marks a pixel whose read failed
    logic [PIXW:0]   fifo_mem_q [PREFETCH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PIXW:0]   push_word;
    logic [PIXW:0]   head;

    // output beat register
    logic                  out_valid_q, out_valid_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  visible_q, visible_d;
    logic [COLOR_BITS-1:0] red_q, red_d;
    logic [COLOR_BITS-1:0] green_q, green_d;
    logic [COLOR_BITS-1:0] blue_q, blue_d;

    logic ar_fire, r_fire, accept, slot_free, pos_visible, load, pop, retire;
    logic unused_rdata;

    // handshake and beat-load decisions for this cycle
    always_comb begin
        ar_fire      = arvalid_q & axi_arready;
        r_fire       = axi_rvalid & rready_q;
        accept       = out_valid_q & out_ready;
        slot_free    = ~out_valid_q | out_ready;
        pos_visible  = (int'(x_q) < H_VISIBLE) && (int'(y_q) < V_VISIBLE);
        load         = enable & slot_free & (~pos_visible | (fifo_cnt_q != '0));
        pop          = load & pos_visible;
        retire       = accept & visible_q;
        push_word    = {(axi_rresp != 2'b00), axi_rdata[PIXW-1:0]};
        head         = fifo_mem_q[rd_ptr_q];
        unused_rdata = ^axi_rdata;
    end

    // fetch address, credit accounting and AR valid
    always_comb begin
        araddr_d    = araddr_q;
        fetch_cnt_d = fetch_cnt_q;
        if (ar_fire) begin
            if (fetch_cnt_q == F_LAST) begin
                fetch_cnt_d = '0;
                araddr_d    = BASE_ADDR;
            end else begin
                fetch_cnt_d = fetch_cnt_q + FW'(1);
                araddr_d    = araddr_q + AXI_ADDR_WIDTH'(1);
            end
        end
        credits_d = credits_q + CW'(ar_fire) - CW'(retire);
        // a pending request holds regardless of enable; a new one needs a free credit
        arvalid_d = (arvalid_q & ~axi_arready) | (enable & (int'(credits_d) < PREFETCH));
        rready_d  = 1'b1;
        rd_err_d  = rd_err_q | (r_fire & (axi_rresp != 2'b00));
    end

    // queue pointer and occupancy updates
    always_comb begin
        wr_ptr_d   = r_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CW'(r_fire) - CW'(pop);
    end

    // output beat register and raster advance
    always_comb begin
        out_valid_d = out_valid_q & ~accept;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        visible_d   = visible_q;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        x_d         = x_q;
        y_d         = y_q;
        if (load) begin
            out_valid_d = 1'b1;
            hsync_d     = !((int'(x_q) >= HS_START) && (int'(x_q) < HS_END));
            vsync_d     = !((int'(y_q) >= VS_START) && (int'(y_q) < VS_END));
            visible_d   = pos_visible;
            if (pos_visible && !head[PIXW]) begin
                red_d   = head[PIXW-1 -: COLOR_BITS];
                green_d = head[2*COLOR_BITS-1 -: COLOR_BITS];
                blue_d  = head[COLOR_BITS-1:0];
            end else begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            araddr_q    <= BASE_ADDR;
            arvalid_q   <= 1'b0;
            fetch_cnt_q <= '0;
            credits_q   <= '0;
            rready_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            visible_q   <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            fetch_cnt_q <= fetch_cnt_d;
            credits_q   <= credits_d;
            rready_q    <= rready_d;
            rd_err_q    <= rd_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            out_valid_q <= out_valid_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            visible_q   <= visible_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    // queue storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (!reset && r_fire) begin
            fifo_mem_q[wr_ptr_q] <= push_word;
        end
    end

    // port drive
    always_comb begin
        axi_araddr  = araddr_q;
        axi_arvalid = arvalid_q;
        axi_rready  = rready_q;
        out_valid   = out_valid_q;
        hsync       = hsync_q;
        vsync       = vsync_q;
        red         = red_q;
        green       = green_q;
        blue        = blue_q;
        visible     = visible_q;
        rd_err      = rd_err_q;
    end

endmodule

// File: tb/tb_vga_fb_pixel_stream.sv
// Bench for vga_fb_pixel_stream in a tiny 7x5 raster mode with a 1-cycle SRAM model.
module tb_vga_fb_pixel_stream;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [19:0] axi_araddr;
    logic        axi_arvalid, axi_arready;
    logic [15:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid, axi_rready;
    logic        out_valid, out_ready;
    logic        hsync, vsync, visible, rd_err;
    logic [3:0]  red, green, blue;

    always #5 clk = ~clk;

    vga_fb_pixel_stream #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .COLOR_BITS(4), .AXI_ADDR_WIDTH(20), .AXI_DATA_WIDTH(16),
        .FB_BASE(0), .PREFETCH(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .out_valid(out_valid), .out_ready(out_ready),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .visible(visible), .rd_err(rd_err)
    );

    typedef struct {
        int addr;
        bit err;
    } rsp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mem [8];
    rsp_t        rq [$];
    bit          bad [8];
    int          exp_x, exp_y, exp_faddr, issued, vis_done, beats, ars;
    bit          err_seen;
    int          ready_pct;
    bit          stall_armed, err_armed, drop_armed;
    int          stall_cnt, err_addr;
    bit          prev_v, prev_r;
    logic [14:0] prev_f;

    task automatic model_clear();
        exp_x = 0; exp_y = 0; exp_faddr = 0; issued = 0; vis_done = 0;
        err_seen = 0; prev_v = 0;
        for (int i = 0; i < 8; i++) bad[i] = 0;
    endtask

    // one clock: check, drive stimulus and SRAM model, score handshakes of the coming edge
    task automatic step();
        logic [14:0] cur_f, exp_f;
        logic [3:0]  er, eg, eb;
        logic        ehs, evs, evis;
        int          pix;
        rsp_t        r;
        @(negedge clk);
        cur_f = {hsync, vsync, visible, red, green, blue};
        if (!reset) begin
            n_checks++;
            if (rd_err !== err_seen) begin
                $display("FAIL rd_err_sticky: got %b expected %b", rd_err, err_seen);
                n_fail++;
            end
            if (prev_v && !prev_r) begin
                n_checks++;
                if (out_valid !== 1'b1 || cur_f !== prev_f) begin
                    $display("FAIL stream_hold: got valid=%b fields=%h expected valid=1 fields=%h",
                             out_valid, cur_f, prev_f);
                    n_fail++;
                end
            end
        end
        out_ready = (int'($urandom_range(99)) < ready_pct);

        axi_arready = 1'b1;
        if (!reset && stall_armed && axi_arvalid === 1'b1 && axi_araddr == 20'd2) begin
            stall_armed = 0;
            stall_cnt   = 10;
        end
        if (stall_cnt > 0) begin
            axi_arready = 1'b0;
            stall_cnt--;
            n_checks++;
            if (axi_arvalid !== 1'b1 || axi_araddr !== 20'd2) begin
                $display("FAIL ar_hold: got arvalid=%b araddr=%0d expected arvalid=1 araddr=2",
                         axi_arvalid, axi_araddr);
                n_fail++;
            end
            if (stall_cnt == 0) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL beat_before_data: got out_valid=%b expected 0", out_valid);
                    n_fail++;
                end
            end
        end

        if (!reset && rq.size() > 0) begin
            r          = rq[0];
            axi_rvalid = 1'b1;
            axi_rdata  = mem[r.addr];
            axi_rresp  = r.err ? 2'b10 : 2'b00;
            if (axi_rready === 1'b1) begin
                void'(rq.pop_front());
                if (r.err) begin
                    err_seen    = 1;
                    bad[r.addr] = 1;
                end
            end
        end else begin
            axi_rvalid = 1'b0;
            axi_rdata  = 16'($urandom);
            axi_rresp  = 2'b00;
        end

        if (!reset && axi_arvalid === 1'b1 && axi_arready) begin
            n_checks++;
            if (axi_araddr !== 20'(exp_faddr)) begin
                $display("FAIL ar_addr: got %0d expected %0d", axi_araddr, exp_faddr);
                n_fail++;
            end
            r.addr = exp_faddr;
            r.err  = err_armed && (exp_faddr == err_addr);
            if (r.err) err_armed = 0;
            rq.push_back(r);
            exp_faddr = (exp_faddr == 7) ? 0 : exp_faddr + 1;
            issued++;
            ars++;
        end

        if (!reset && out_valid === 1'b1 && out_ready) begin
            evis = (exp_x < 4) && (exp_y < 2);
            ehs  = (exp_x != 5);
            evs  = (exp_y != 3);
            {er, eg, eb} = 12'h000;
            if (evis) begin
                pix = exp_y * 4 + exp_x;
                if (bad[pix]) bad[pix] = 0;
                else {er, eg, eb} = mem[pix][11:0];
            end
            exp_f = {ehs, evs, evis, er, eg, eb};
            n_checks++;
            if (cur_f !== exp_f) begin
                $display("FAIL beat(%0d,%0d): got {hs,vs,vis,rgb}=%h expected %h",
                         exp_x, exp_y, cur_f, exp_f);
                n_fail++;
            end
            if (drop_armed && exp_x == 6 && exp_y == 1) begin
                enable     = 1'b0;
                drop_armed = 0;
            end
            if (exp_x == 6) begin
                exp_x = 0;
                exp_y = (exp_y == 4) ? 0 : exp_y + 1;
            end else begin
                exp_x++;
            end
            beats++;
            if (evis) vis_done++;
        end

        if (!reset) begin
            n_checks++;
            if (issued - vis_done > 4) begin
                $display("FAIL credits: got %0d outstanding expected <= 4", issued - vis_done);
                n_fail++;
            end
        end
        prev_v = !reset && (out_valid === 1'b1);
        prev_r = out_ready;
        prev_f = cur_f;
    endtask

    task automatic run_beats(input int n, input int budget, input string name);
        int start = beats;
        int k = 0;
        while (beats < start + n && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (beats < start + n) begin
            $display("FAIL timeout_%s: got %0d beats expected %0d", name, beats - start, n);
            n_fail++;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        rq.delete();
        stall_cnt = 0;
        repeat (3) step();
        model_clear();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        rq.delete();
        repeat (3) step();
        n_checks++;
        if (out_valid !== 1'b0 || axi_arvalid !== 1'b0 || axi_rready !== 1'b0) begin
            $display("FAIL reset_valids: got out_valid=%b arvalid=%b rready=%b expected 0 0 0",
                     out_valid, axi_arvalid, axi_rready);
            n_fail++;
        end
        n_checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            $display("FAIL reset_sync: got hsync=%b vsync=%b expected 1 1", hsync, vsync);
            n_fail++;
        end
        n_checks++;
        if ({red, green, blue, visible, rd_err} !== 14'h0 || axi_araddr !== 20'd0) begin
            $display("FAIL reset_fields: got rgb=%h vis=%b rd_err=%b araddr=%0d expected 0",
                     {red, green, blue}, visible, rd_err, axi_araddr);
            n_fail++;
        end
        model_clear();
        reset = 1'b0;
    endtask

    task automatic test_frame();
        int a0 = ars;
        run_beats(35, 500, "frame");
        n_checks++;
        if (ars - a0 < 9) begin
            $display("FAIL ar_wrap: got %0d reads expected >= 9", ars - a0);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_pct = 50;
        run_beats(35, 1000, "backpressure");
        ready_pct = 100;
    endtask

    task automatic test_ar_stall();
        do_reset();
        stall_armed = 1;
        run_beats(12, 200, "ar_stall");
        n_checks++;
        if (stall_armed) begin
            $display("FAIL stall_trigger: got araddr 2 never offered expected offered");
            n_fail++;
            stall_armed = 0;
        end
    endtask

    task automatic test_rd_err();
        do_reset();
        err_armed = 1;
        err_addr  = 3;
        run_beats(40, 500, "rd_err");
        n_checks++;
        if (rd_err !== 1'b1) begin
            $display("FAIL rd_err_after_wrap: got %b expected 1", rd_err);
            n_fail++;
        end
        err_armed = 0;
    endtask

    task automatic test_reset_midline();
        int k = 0;
        do_reset();
        while (!(beats >= 2 && issued - vis_done >= 2) && k < 100) begin
            step();
            k++;
        end
        reset = 1'b1;
        rq.delete();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || axi_arvalid !== 1'b0) begin
            $display("FAIL midline_reset: got out_valid=%b arvalid=%b expected 0 0",
                     out_valid, axi_arvalid);
            n_fail++;
        end
        step();
        model_clear();
        reset = 1'b0;
        run_beats(12, 200, "after_reset");
    endtask

    task automatic test_enable_drop();
        int k = 0;
        int b0, a0;
        do_reset();
        drop_armed = 1;
        while (enable && k < 300) begin
            step();
            k++;
        end
        n_checks++;
        if (enable) begin
            $display("FAIL timeout_drop: got beat (6,1) never accepted expected accepted");
            n_fail++;
            drop_armed = 0;
        end
        b0 = beats;
        a0 = ars;
        repeat (12) step();
        n_checks++;
        if (beats != b0 || ars != a0) begin
            $display("FAIL disabled_quiet: got %0d beats %0d reads expected 0 0",
                     beats - b0, ars - a0);
            n_fail++;
        end
        n_checks++;
        if (out_valid !== 1'b0 || axi_arvalid !== 1'b0) begin
            $display("FAIL disabled_valids: got out_valid=%b arvalid=%b expected 0 0",
                     out_valid, axi_arvalid);
            n_fail++;
        end
        enable = 1'b1;
        run_beats(25, 300, "reenable");
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; out_ready = 1'b0; axi_arready = 1'b0;
        axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
        ready_pct = 100; stall_armed = 0; err_armed = 0; drop_armed = 0;
        stall_cnt = 0; err_addr = 0; beats = 0; ars = 0;
        prev_r = 0; prev_f = '0;
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        model_clear();
        test_reset();
        test_frame();
        test_backpressure();
        test_ar_stall();
        test_rd_err();
        test_reset_midline();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
